bot_multi_if: RTL and testbench

- PicoBlaze I/O register interface serving NUM_BOTS Rojobots from one BOT-simulator PicoBlaze.
- AddrIn[7:4] selects the bot bank; AddrIn[3:0] selects the register within the bank.
- Per-bot holding registers are copied atomically into system-visible registers on a load command.
- Per-bot update flag is a level-held, acknowledged handshake, not a toggle.

---
 rtl/bot_multi_if_pkg.sv | 31 +++
 rtl/bot_if_bank.sv | 110 +++++++++++
 rtl/bot_multi_if.sv | 148 ++++++++++++++
 tb/tb_bot_multi_if.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bot_multi_if_pkg.sv
// Shared constants for the multi-bot PicoBlaze register interface:
// register offsets, fixed read-back values and default field widths.
package bot_multi_if_pkg;

    localparam int ORIENT_W_DEF = 3;

    localparam logic [3:0] REG_MOTCTL  = 4'h0;
    localparam logic [3:0] REG_LOCX    = 4'h1;
    localparam logic [3:0] REG_LOCY    = 4'h2;
    localparam logic [3:0] REG_BOTINFO = 4'h3;
    localparam logic [3:0] REG_SENSORS = 4'h4;
    localparam logic [3:0] REG_RSVD_5  = 4'h5;
    localparam logic [3:0] REG_RSVD_6  = 4'h6;
    localparam logic [3:0] REG_BOTCFG  = 4'h7;
    localparam logic [3:0] REG_MAPX    = 4'h8;
    localparam logic [3:0] REG_MAPY    = 4'h9;
    localparam logic [3:0] REG_MAPVAL  = 4'hA;
    localparam logic [3:0] REG_RSVD_B  = 4'hB;
    localparam logic [3:0] REG_LOAD    = 4'hC;
    localparam logic [3:0] REG_RSVD_D  = 4'hD;
    localparam logic [3:0] REG_UPD     = 4'hE;
    localparam logic [3:0] REG_RSVD_F  = 4'hF;

    localparam logic [7:0] RD_VAL_5 = 8'h55;
    localparam logic [7:0] RD_VAL_6 = 8'h66;
    localparam logic [7:0] RD_VAL_8 = 8'h88;
    localparam logic [7:0] RD_VAL_9 = 8'h99;
    localparam logic [7:0] RD_VAL_B = 8'hBB;
    localparam logic [7:0] RD_VAL_F = 8'hAA;

endpackage

// File: rtl/bot_if_bank.sv
// One bot's holding/system registers, load pulse, update flag and, with
// BOT_MULTI_IF_UPD_CNT_EN defined, an 8-bit load counter behind register 0xF.
module bot_if_bank
    import bot_multi_if_pkg::*;
#(
    parameter int ORIENT_W = ORIENT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [3:0]          reg_addr,
    input  logic [7:0]          data_in,
    input  logic                orient_ovr_en,
    input  logic [ORIENT_W-1:0] orient_ovr,
    input  logic                upd_ack,
    output logic [7:0]          loc_x_int,
    output logic [7:0]          loc_y_int,
    output logic [7:0]          bot_info_int,
    output logic [7:0]          sensors_int,
    output logic [7:0]          loc_x,
    output logic [7:0]          loc_y,
    output logic [7:0]          bot_info,
    output logic [7:0]          sensors,
    output logic                upd_flag,
    output logic [7:0]          reg_f
);

    logic [7:0] loc_x_int_r, loc_y_int_r, bot_info_int_r, sensors_int_r;
    logic [7:0] loc_x_r, loc_y_r, bot_info_r, sensors_r;
    logic       load_pulse_r;
    logic       upd_r;
    logic [7:0] bot_info_wr_s;

    // Orientation override replaces only the low ORIENT_W bits of the written byte
    always_comb begin
        bot_info_wr_s = data_in;
        if (orient_ovr_en) begin
            bot_info_wr_s[ORIENT_W-1:0] = orient_ovr;
        end else begin
            bot_info_wr_s = data_in;
        end
    end

    // Holding writes, registered load pulse, atomic copy and update handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            loc_x_int_r    <= 8'h00;
            loc_y_int_r    <= 8'h00;
            bot_info_int_r <= 8'h00;
            sensors_int_r  <= 8'h00;
            loc_x_r        <= 8'h00;
            loc_y_r        <= 8'h00;
            bot_info_r     <= 8'h00;
            sensors_r      <= 8'h00;
            load_pulse_r   <= 1'b0;
            upd_r          <= 1'b0;
        end else begin
            load_pulse_r <= wr_en && (reg_addr == REG_LOAD);
            if (wr_en) begin
                case (reg_addr)
                    REG_LOCX:    loc_x_int_r    <= data_in;
                    REG_LOCY:    loc_y_int_r    <= data_in;
                    REG_BOTINFO: bot_info_int_r <= bot_info_wr_s;
                    REG_SENSORS: sensors_int_r  <= data_in;
                    default:     ;
                endcase
            end
            // Copy uses pre-edge holding values, so a same-cycle write lands in holding only
            if (load_pulse_r) begin
                loc_x_r    <= loc_x_int_r;
                loc_y_r    <= loc_y_int_r;
                bot_info_r <= bot_info_int_r;
                sensors_r  <= sensors_int_r;
            end
            if (wr_en && (reg_addr == REG_UPD)) begin
                upd_r <= 1'b1;
            end else if (upd_ack) begin
                upd_r <= 1'b0;
            end
        end
    end

`ifdef BOT_MULTI_IF_UPD_CNT_EN
    logic [7:0] load_cnt_r;

    // Load counter, wraps naturally from 255 to 0
    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt_r <= 8'h00;
        end else if (load_pulse_r) begin
            load_cnt_r <= load_cnt_r + 8'h01;
        end
    end

    assign reg_f = load_cnt_r;
`else
    assign reg_f = RD_VAL_F;
`endif

    assign loc_x_int    = loc_x_int_r;
    assign loc_y_int    = loc_y_int_r;
    assign bot_info_int = bot_info_int_r;
    assign sensors_int  = sensors_int_r;
    assign loc_x        = loc_x_r;
    assign loc_y        = loc_y_r;
    assign bot_info     = bot_info_r;
    assign sensors      = sensors_r;
    assign upd_flag     = upd_r;

endmodule

// File: rtl/bot_multi_if.sv
// PicoBlaze I/O interface for NUM_BOTS Rojobots: bank decode, read mux and shared
// map registers. Optional macro BOT_MULTI_IF_UPD_CNT_EN enables per-bot load counters.
module bot_multi_if
    import bot_multi_if_pkg::*;
#(
    parameter int         NUM_BOTS     = 4,
    parameter int         ORIENT_W     = ORIENT_W_DEF,
    parameter logic [7:0] BAD_BANK_VAL = 8'hEE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         Wr_Strobe,
    input  logic                         Rd_Strobe,
    input  logic [7:0]                   AddrIn,
    input  logic [7:0]                   DataIn,
    output logic [7:0]                   DataOut,
    input  logic [8*NUM_BOTS-1:0]        MotCtl,
    input  logic [8*NUM_BOTS-1:0]        BotConfig,
    input  logic [NUM_BOTS-1:0]          OrientOvrEn,
    input  logic [ORIENT_W*NUM_BOTS-1:0] OrientOvr,
    output logic [8*NUM_BOTS-1:0]        LocX,
    output logic [8*NUM_BOTS-1:0]        LocY,
    output logic [8*NUM_BOTS-1:0]        BotInfo,
    output logic [8*NUM_BOTS-1:0]        Sensors,
    output logic [7:0]                   MapX,
    output logic [7:0]                   MapY,
    output logic [3:0]                   MapBot,
    input  logic [1:0]                   MapVal,
    output logic [NUM_BOTS-1:0]          upd_sysregs,
    input  logic [NUM_BOTS-1:0]          upd_ack
);

    localparam logic [4:0] NUM_BOTS_W = 5'(NUM_BOTS);

    logic [3:0] bank_s;
    logic [3:0] reg_s;
    logic       bank_ok_s;
    logic       wr_ok_s;
    logic [7:0] rd_data_s;
    logic [7:0] data_out_r, map_x_r, map_y_r;
    logic [3:0] map_bot_r;
    logic       unused_rd_strobe_s;

    // Per-bank read-back arrays sized for the full 16-bank address space
    logic [7:0] mot_s [16];
    logic [7:0] cfg_s [16];
    logic [7:0] hx_s  [16];
    logic [7:0] hy_s  [16];
    logic [7:0] hi_s  [16];
    logic [7:0] hs_s  [16];
    logic [7:0] rf_s  [16];
    logic       upd_s [16];

    assign bank_s             = AddrIn[7:4];
    assign reg_s              = AddrIn[3:0];
    assign bank_ok_s          = ({1'b0, bank_s} < NUM_BOTS_W);
    assign wr_ok_s            = Wr_Strobe && bank_ok_s;
    assign unused_rd_strobe_s = Rd_Strobe;

    for (genvar b = 0; b < 16; b++) begin : g_bank
        if (b < NUM_BOTS) begin : g_on
            bot_if_bank #(.ORIENT_W(ORIENT_W)) u_bank (
                .clk          (clk),
                .reset        (reset),
                .wr_en        (wr_ok_s && (bank_s == 4'(b))),
                .reg_addr     (reg_s),
                .data_in      (DataIn),
                .orient_ovr_en(OrientOvrEn[b]),
                .orient_ovr   (OrientOvr[ORIENT_W*b +: ORIENT_W]),
                .upd_ack      (upd_ack[b]),
                .loc_x_int    (hx_s[b]),
                .loc_y_int    (hy_s[b]),
                .bot_info_int (hi_s[b]),
                .sensors_int  (hs_s[b]),
                .loc_x        (LocX[8*b +: 8]),
                .loc_y        (LocY[8*b +: 8]),
                .bot_info     (BotInfo[8*b +: 8]),
                .sensors      (Sensors[8*b +: 8]),
                .upd_flag     (upd_s[b]),
                .reg_f        (rf_s[b])
            );
            assign mot_s[b]       = MotCtl[8*b +: 8];
            assign cfg_s[b]       = BotConfig[8*b +: 8];
            assign upd_sysregs[b] = upd_s[b];
        end else begin : g_off
            assign mot_s[b] = 8'h00;
            assign cfg_s[b] = 8'h00;
            assign hx_s[b]  = 8'h00;
            assign hy_s[b]  = 8'h00;
            assign hi_s[b]  = 8'h00;
            assign hs_s[b]  = 8'h00;
            assign rf_s[b]  = 8'h00;
            assign upd_s[b] = 1'b0;
        end
    end

    // Read mux: fixed values for reserved offsets, bad-bank value outside NUM_BOTS
    always_comb begin
        rd_data_s = BAD_BANK_VAL;
        if (bank_ok_s) begin
            case (reg_s)
                REG_MOTCTL:  rd_data_s = mot_s[bank_s];
                REG_LOCX:    rd_data_s = hx_s[bank_s];
                REG_LOCY:    rd_data_s = hy_s[bank_s];
                REG_BOTINFO: rd_data_s = hi_s[bank_s];
                REG_SENSORS: rd_data_s = hs_s[bank_s];
                REG_RSVD_5:  rd_data_s = RD_VAL_5;
                REG_RSVD_6:  rd_data_s = RD_VAL_6;
                REG_BOTCFG:  rd_data_s = cfg_s[bank_s];
                REG_MAPX:    rd_data_s = RD_VAL_8;
                REG_MAPY:    rd_data_s = RD_VAL_9;
                REG_MAPVAL:  rd_data_s = {6'b000000, MapVal};
                REG_RSVD_B:  rd_data_s = RD_VAL_B;
                REG_UPD:     rd_data_s = {7'b0000000, upd_s[bank_s]};
                REG_RSVD_F:  rd_data_s = rf_s[bank_s];
                default:     rd_data_s = 8'h00;
            endcase
        end else begin
            rd_data_s = BAD_BANK_VAL;
        end
    end

    // Registered read data and the shared world-map address registers
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_r <= 8'h00;
            map_x_r    <= 8'h00;
            map_y_r    <= 8'h00;
            map_bot_r  <= 4'h0;
        end else begin
            data_out_r <= rd_data_s;
            if (wr_ok_s && (reg_s == REG_MAPX)) begin
                map_x_r   <= DataIn;
                map_bot_r <= bank_s;
            end
            if (wr_ok_s && (reg_s == REG_MAPY)) begin
                map_y_r   <= DataIn;
                map_bot_r <= bank_s;
            end
        end
    end

    assign DataOut = data_out_r;
    assign MapX    = map_x_r;
    assign MapY    = map_y_r;
    assign MapBot  = map_bot_r;

endmodule

// File: tb/tb_bot_multi_if.sv
// Directed self-checking bench for bot_multi_if with NUM_BOTS=4; the register
// 0xF expectation follows BOT_MULTI_IF_UPD_CNT_EN.
module tb_bot_multi_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        Wr_Strobe, Rd_Strobe;
    logic [7:0]  AddrIn, DataIn, DataOut;
    logic [31:0] MotCtl, BotConfig, LocX, LocY, BotInfo, Sensors;
    logic [3:0]  OrientOvrEn, upd_sysregs, upd_ack, MapBot;
    logic [11:0] OrientOvr;
    logic [7:0]  MapX, MapY;
    logic [1:0]  MapVal;

    int n_vec = 0;
    int n_bad = 0;

    bot_multi_if #(.NUM_BOTS(4), .ORIENT_W(3), .BAD_BANK_VAL(8'hEE)) dut (
        .clk(clk), .reset(reset), .Wr_Strobe(Wr_Strobe), .Rd_Strobe(Rd_Strobe),
        .AddrIn(AddrIn), .DataIn(DataIn), .DataOut(DataOut),
        .MotCtl(MotCtl), .BotConfig(BotConfig), .OrientOvrEn(OrientOvrEn),
        .OrientOvr(OrientOvr), .LocX(LocX), .LocY(LocY), .BotInfo(BotInfo),
        .Sensors(Sensors), .MapX(MapX), .MapY(MapY), .MapBot(MapBot),
        .MapVal(MapVal), .upd_sysregs(upd_sysregs), .upd_ack(upd_ack)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] bank, input logic [3:0] rg, input logic [7:0] d);
        Wr_Strobe = 1'b1;
        AddrIn    = {bank, rg};
        DataIn    = d;
        tick();
        Wr_Strobe = 1'b0;
    endtask

    task automatic rd(input logic [3:0] bank, input logic [3:0] rg);
        Rd_Strobe = 1'b1;
        AddrIn    = {bank, rg};
        tick();
        Rd_Strobe = 1'b0;
    endtask

    initial begin
        reset = 1'b1; Wr_Strobe = 1'b0; Rd_Strobe = 1'b0;
        AddrIn = 8'h00; DataIn = 8'h00; MapVal = 2'b00;
        MotCtl = 32'h44332211; BotConfig = 32'hD4C3B2A1;
        OrientOvrEn = 4'b0000; OrientOvr = 12'h000; upd_ack = 4'b0000;
        tick(); tick();
        check_val("rst_dataout", {24'h0, DataOut}, 32'h0);
        check_val("rst_locx", LocX, 32'h0);
        check_val("rst_upd", {28'h0, upd_sysregs}, 32'h0);
        check_val("rst_mapbot", {28'h0, MapBot}, 32'h0);
        reset = 1'b0;

        rd(4'd0, 4'h1); check_val("rd_b0_locx", {24'h0, DataOut}, 32'h00);
        rd(4'd5, 4'h1); check_val("rd_bad_bank", {24'h0, DataOut}, 32'hEE);
        rd(4'd2, 4'h0); check_val("rd_motctl2", {24'h0, DataOut}, 32'h33);
        rd(4'd1, 4'h7); check_val("rd_botcfg1", {24'h0, DataOut}, 32'hB2);
        rd(4'd0, 4'h5); check_val("rd_rsvd5", {24'h0, DataOut}, 32'h55);
        rd(4'd3, 4'hB); check_val("rd_rsvdB", {24'h0, DataOut}, 32'hBB);
        rd(4'd0, 4'hC); check_val("rd_loadreg", {24'h0, DataOut}, 32'h00);

        // Bank 2 load
        wr(4'd2, 4'h1, 8'h3C);
        wr(4'd2, 4'h2, 8'h5A);
        rd(4'd2, 4'h1); check_val("hold_locx2", {24'h0, DataOut}, 32'h3C);
        check_val("sys_locx_preload", LocX, 32'h0);
        wr(4'd2, 4'hC, 8'h00);
        check_val("sys_locx_pulse_cyc", LocX, 32'h0);
        tick();
        check_val("load_locx", LocX, 32'h003C0000);
        check_val("load_locy", LocY, 32'h005A0000);

        // Orientation override on bot 1
        OrientOvrEn = 4'b0010; OrientOvr = 12'b000_000_101_000;
        wr(4'd1, 4'h3, 8'hF8);
        OrientOvrEn = 4'b0000;
        rd(4'd1, 4'h3); check_val("botinfo_int1", {24'h0, DataOut}, 32'hFD);
        wr(4'd1, 4'hC, 8'h00); tick();
        check_val("load_botinfo", BotInfo, 32'h0000FD00);

        // Holding write coincident with load pulse: system gets old value
        wr(4'd0, 4'h1, 8'h11);
        wr(4'd0, 4'hC, 8'h00);
        wr(4'd0, 4'h1, 8'h22);
        check_val("coinc_sys_old", LocX, 32'h003C0011);
        rd(4'd0, 4'h1); check_val("coinc_hold_new", {24'h0, DataOut}, 32'h22);

        // Update handshake
        wr(4'd3, 4'hE, 8'h00);
        check_val("upd_set", {28'h0, upd_sysregs}, 32'h8);
        repeat (10) tick();
        check_val("upd_hold", {28'h0, upd_sysregs}, 32'h8);
        rd(4'd3, 4'hE); check_val("rd_upd3", {24'h0, DataOut}, 32'h01);
        upd_ack = 4'b1000;
        wr(4'd3, 4'hE, 8'h00);
        check_val("upd_set_wins", {28'h0, upd_sysregs}, 32'h8);
        tick();
        upd_ack = 4'b0000;
        check_val("upd_ack_clr", {28'h0, upd_sysregs}, 32'h0);

        // Shared map registers
        wr(4'd1, 4'h8, 8'h10);
        wr(4'd2, 4'h9, 8'h20);
        check_val("mapx", {24'h0, MapX}, 32'h10);
        check_val("mapy", {24'h0, MapY}, 32'h20);
        check_val("mapbot", {28'h0, MapBot}, 32'h2);
        wr(4'd4, 4'h8, 8'h77);
        check_val("mapx_badbank_ign", {24'h0, MapX}, 32'h10);
        check_val("mapbot_badbank_ign", {28'h0, MapBot}, 32'h2);
        MapVal = 2'b11;
        rd(4'd0, 4'hA); check_val("rd_mapval", {24'h0, DataOut}, 32'h03);

        // Reset right after a load command discards the load
        wr(4'd2, 4'h1, 8'h99);
        AddrIn = 8'h21;
        wr(4'd2, 4'hC, 8'h00);
        reset = 1'b1;
        AddrIn = 8'h21;
        tick();
        check_val("midrst_locx", LocX, 32'h0);
        check_val("midrst_dataout", {24'h0, DataOut}, 32'h0);
        check_val("midrst_mapx", {24'h0, MapX}, 32'h0);
        reset = 1'b0;

        // 257 loads on bank 0
        for (int i = 0; i < 257; i++) wr(4'd0, 4'hC, 8'h00);
        tick();
        rd(4'd0, 4'hF);
`ifdef BOT_MULTI_IF_UPD_CNT_EN
        check_val("rd_load_cnt", {24'h0, DataOut}, 32'h01);
`else
        check_val("rd_rsvdF", {24'h0, DataOut}, 32'hAA);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
